stripe_sequencer: RTL

STRIPE_SEQUENCER -- requirements
Module: stripe_sequencer

---
 rtl/stripe_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/stripe_sequencer.sv
// Stripe sequencer: walks an erasure-coding job stripe by stripe, feeding
// data chunks into the parity engine, waiting out the engine pipeline and
// then writing the parity words to the output buffer.
module stripe_sequencer #(
    parameter int K_MAX   = 16,
    parameter int M_MAX   = 4,
    parameter int ENG_LAT = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  cfg_k,
    input  logic [2:0]  cfg_m,
    input  logic [15:0] cfg_stripes,
    input  logic        inbuff_valid,
    input  logic        outbuff_ready,
    output logic        inbuff_rd_en,
    output logic        bm_rd_en,
    output logic [3:0]  bm_rd_addr,
    output logic        eng_calc_en,
    output logic        eng_first,
    output logic        eng_last,
    output logic        outbuff_wr_en,
    output logic [1:0]  outbuff_wr_sel,
    output logic        busy,
    output logic        done,
    output logic        cfg_err,
    output logic [15:0] stripe_cnt
);

    typedef enum logic [2:0] {IDLE, CALC, DRAIN, WRITE, DONE} state_t;

    localparam logic [4:0] K_LIM    = 5'(K_MAX);
    localparam logic [2:0] M_LIM    = 3'(M_MAX);
    localparam logic [3:0] LAT_INIT = 4'(ENG_LAT - 1);

    state_t      state_q, state_d;
    logic [4:0]  k_q, k_d;
    logic [2:0]  m_q, m_d;
    logic [15:0] stripes_q, stripes_d;
    logic [4:0]  chunk_q, chunk_d;
    logic [2:0]  par_q, par_d;
    logic [3:0]  lat_q, lat_d;
    logic [15:0] stripe_cnt_q, stripe_cnt_d;

    logic cfg_bad;
    logic beat;
    logic wr;
    logic last_chunk;
    logic last_par;
    logic [15:0] cnt_inc;

    // Handshake qualifiers shared by the next-state logic and the outputs.
    always_comb begin
        cfg_bad    = (cfg_k == 5'd0) || (cfg_k > K_LIM) ||
                     (cfg_m == 3'd0) || (cfg_m > M_LIM) ||
                     (cfg_stripes == 16'd0);
        beat       = (state_q == CALC)  && inbuff_valid  && !abort;
        wr         = (state_q == WRITE) && outbuff_ready && !abort;
        last_chunk = (chunk_q == k_q - 5'd1);
        last_par   = (par_q == m_q - 3'd1);
        cnt_inc    = stripe_cnt_q + 16'd1;
    end

    // Next-state and counter update; abort overrides everything.
    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        k_d          = k_q;
        m_d          = m_q;
        stripes_d    = stripes_q;
        chunk_d      = chunk_q;
        par_d        = par_q;
        lat_d        = lat_q;
        stripe_cnt_d = stripe_cnt_q;

        if (abort) begin
            state_d = IDLE;
            chunk_d = 5'd0;
            par_d   = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !cfg_bad) begin
                        k_d          = cfg_k;
                        m_d          = cfg_m;
                        stripes_d    = cfg_stripes;
                        stripe_cnt_d = 16'd0;
                        chunk_d      = 5'd0;
                        par_d        = 3'd0;
                        state_d      = CALC;
                    end
                end
                CALC: begin
                    if (beat) begin
                        if (last_chunk) begin
                            chunk_d = 5'd0;
                            lat_d   = LAT_INIT;
                            state_d = DRAIN;
                        end else begin
                            chunk_d = chunk_q + 5'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (lat_q == 4'd0) begin
                        par_d   = 3'd0;
                        state_d = WRITE;
                    end else begin
                        lat_d = lat_q - 4'd1;
                    end
                end
                WRITE: begin
                    if (wr) begin
                        if (last_par) begin
                            par_d        = 3'd0;
                            chunk_d      = 5'd0;
                            stripe_cnt_d = cnt_inc;
                            state_d      = (cnt_inc == stripes_q) ? DONE : CALC;
                        end else begin
                            par_d = par_q + 3'd1;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rstn) begin
            state_q      <= IDLE;
            k_q          <= 5'd0;
            m_q          <= 3'd0;
            stripes_q    <= 16'd0;
            chunk_q      <= 5'd0;
            par_q        <= 3'd0;
            lat_q        <= 4'd0;
            stripe_cnt_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            m_q          <= m_d;
            stripes_q    <= stripes_d;
            chunk_q      <= chunk_d;
            par_q        <= par_d;
            lat_q        <= lat_d;
            stripe_cnt_q <= stripe_cnt_d;
        end
    end

    // Zero-latency output decode from state, counters and live handshakes.
    always_comb begin
        inbuff_rd_en   = beat;
        bm_rd_en       = beat;
        eng_calc_en    = beat;
        bm_rd_addr     = chunk_q[3:0];
        eng_first      = beat && (chunk_q == 5'd0);
        eng_last       = beat && last_chunk;
        outbuff_wr_en  = wr;
        outbuff_wr_sel = par_q[1:0];
        busy           = (state_q == CALC) || (state_q == DRAIN) || (state_q == WRITE);
        done           = (state_q == DONE) && !abort;
        cfg_err        = rstn && (state_q == IDLE) && start && cfg_bad && !abort;
        stripe_cnt     = stripe_cnt_q;
    end

endmodule
